// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - demand-driven multi-phase traffic light sequencer
// Walks phases through GREEN/TURN/YELLOW/ALLRED on a 1 s tick, with a flashing-yellow night mode.
module traffic_phase_controller #(
  parameter int NUM_PHASES = 4,
  parameter int TICK_DIV   = 100,
  parameter int GREEN_S    = 30,
  parameter int TURN_S     = 5,
  parameter int YELLOW_S   = 3,
  parameter int ALLRED_S   = 2,
  localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  blink_i,
  input  logic [NUM_PHASES-1:0] demand_i,
  output logic [NUM_PHASES-1:0] green_o,
  output logic [NUM_PHASES-1:0] yellow_o,
  output logic [NUM_PHASES-1:0] red_o,
  output logic [NUM_PHASES-1:0] turn_o,
  output logic [PW-1:0]         cur_phase_o,
  output logic [7:0]            sec_left_o,
  output logic                  flashing_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_GREEN,
    S_TURN,
    S_YELLOW,
    S_ALLRED,
    S_FLASH
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         div_q, div_d;
  logic                  tick;
  logic                  blink_meta_q, blink_s_q;
  logic [NUM_PHASES-1:0] dem_q, dem_d, dem_clr;
  logic [NUM_PHASES-1:0] dem_other, dem_rot, cur_oh_q;
  logic [PW-1:0]         cur_q, cur_d, nxt_q, nxt_d, pick;
  logic                  pick_vld;
  logic [7:0]            sec_q, sec_d;
  logic                  flash_q, flash_d;
  logic [NUM_PHASES-1:0] green_q, green_d, yellow_q, yellow_d;
  logic [NUM_PHASES-1:0] red_q, red_d, turn_q, turn_d, cur_oh;
  logic                  flashing_q, flashing_d;

  assign tick  = (div_q == CW'(TICK_DIV - 1));
  assign div_d = tick ? '0 : div_q + CW'(1);

  assign dem_d = (dem_q | demand_i) & ~dem_clr;

  // Rotate so bit d holds the request d phases after cur; own phase is masked out.
  assign cur_oh_q  = NUM_PHASES'(1) << cur_q;
  assign dem_other = dem_q & ~cur_oh_q;
  assign dem_rot   = (dem_other >> cur_q) | (dem_other << (NUM_PHASES - int'(cur_q)));

  always_comb begin
    int s;
    s        = 0;
    pick     = cur_q;
    pick_vld = 1'b0;
    for (int d = NUM_PHASES - 1; d >= 0; d--) begin
      if (dem_rot[d]) begin
        s = int'(cur_q) + d;
        if (s >= NUM_PHASES) s = s - NUM_PHASES;
        pick     = PW'(s);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    sec_d      = sec_q;
    flash_d    = flash_q;
    dem_clr    = '0;
    green_d    = '0;
    yellow_d   = '0;
    red_d      = '1;
    turn_d     = '0;
    flashing_d = 1'b0;
    cur_oh     = '0;

    if (tick) begin
      case (state_q)
        S_GREEN: begin
          if (sec_q > 8'd1) begin
            sec_d = sec_q - 8'd1;
          end else if (blink_s_q) begin
            state_d = S_YELLOW;
            sec_d   = 8'(YELLOW_S);
          end else if (pick_vld) begin
            nxt_d = pick;
            if (TURN_S > 0) begin
              state_d = S_TURN;
              sec_d   = 8'(TURN_S);
            end else begin
              state_d = S_YELLOW;
              sec_d   = 8'(YELLOW_S);
            end
          end else begin
            sec_d = 8'(GREEN_S);
          end
        end
        S_TURN: begin
          if (sec_q > 8'd1) begin
            sec_d = sec_q - 8'd1;
          end else begin
            state_d = S_YELLOW;
            sec_d   = 8'(YELLOW_S);
          end
        end
        S_YELLOW: begin
          if (sec_q > 8'd1) begin
            sec_d = sec_q - 8'd1;
          end else begin
            state_d = S_ALLRED;
            sec_d   = 8'(ALLRED_S);
          end
        end
        S_ALLRED: begin
          if (sec_q > 8'd1) begin
            sec_d = sec_q - 8'd1;
          end else if (blink_s_q) begin
            state_d = S_FLASH;
            sec_d   = 8'd0;
            flash_d = 1'b1;
          end else begin
            state_d = S_GREEN;
            cur_d   = nxt_q;
            sec_d   = 8'(GREEN_S);
            dem_clr = NUM_PHASES'(1) << nxt_q;
          end
        end
        S_FLASH: begin
          if (!blink_s_q) begin
            state_d = S_ALLRED;
            cur_d   = '0;
            nxt_d   = '0;
            sec_d   = 8'(ALLRED_S);
          end else begin
            flash_d = ~flash_q;
          end
        end
        default: begin
          state_d = S_ALLRED;
          sec_d   = 8'(ALLRED_S);
        end
      endcase
    end

    // Lamps follow the next state so they register together with it.
    cur_oh = NUM_PHASES'(1) << cur_d;
    case (state_d)
      S_GREEN: begin
        green_d = cur_oh;
        red_d   = ~cur_oh;
      end
      S_TURN: begin
        green_d = cur_oh;
        turn_d  = cur_oh;
        red_d   = ~cur_oh;
      end
      S_YELLOW: begin
        yellow_d = cur_oh;
        red_d    = ~cur_oh;
      end
      S_FLASH: begin
        red_d      = '0;
        yellow_d   = flash_d ? '1 : '0;
        flashing_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_ALLRED;
      div_q        <= '0;
      blink_meta_q <= 1'b0;
      blink_s_q    <= 1'b0;
      dem_q        <= '0;
      cur_q        <= '0;
      nxt_q        <= '0;
      sec_q        <= 8'(ALLRED_S);
      flash_q      <= 1'b0;
      green_q      <= '0;
      yellow_q     <= '0;
      red_q        <= '1;
      turn_q       <= '0;
      flashing_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      blink_meta_q <= blink_i;
      blink_s_q    <= blink_meta_q;
      dem_q        <= dem_d;
      cur_q        <= cur_d;
      nxt_q        <= nxt_d;
      sec_q        <= sec_d;
      flash_q      <= flash_d;
      green_q      <= green_d;
      yellow_q     <= yellow_d;
      red_q        <= red_d;
      turn_q       <= turn_d;
      flashing_q   <= flashing_d;
    end
  end

  assign green_o     = green_q;
  assign yellow_o    = yellow_q;
  assign red_o       = red_q;
  assign turn_o      = turn_q;
  assign cur_phase_o = cur_q;
  assign sec_left_o  = sec_q;
  assign flashing_o  = flashing_q;

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Parametrised successor to the two-road traffic light controller.
- Sequences NUM_PHASES signal phases (phase 0 = main road) through green, optional turn arrow, yellow and all-red.
- Serves only phases with latched demand; rests in green when no other phase is waiting.
- Supports a flashing-yellow night mode on `blink`; sits between the board clock/switches and the lamp drivers.

Parameters:
- NUM_PHASES, 4, number of phases (2..8)
- TICK_DIV, 100, clk cycles per 1 s tick (100 Hz board clock)
- GREEN_S, 30, green duration in ticks (1..255)
- TURN_S, 5, turn-arrow duration in ticks (0 = skip TURN state)
- YELLOW_S, 3, yellow duration in ticks (1..255)
- ALLRED_S, 2, all-red clearance in ticks (1..255)

Ports:
- clk, in, 1, system clock
- rst, in, 1, asynchronous active-high reset
- blink, in, 1, asynchronous night-mode request from switch
- demand, in, NUM_PHASES, per-phase request pulses/levels
- green, out, NUM_PHASES, green lamp per phase
- yellow, out, NUM_PHASES, yellow lamp per phase
- red, out, NUM_PHASES, red lamp per phase
- turn, out, NUM_PHASES, turn arrow per phase
- cur_phase, out, PW = max(1,clog2(NUM_PHASES)), phase currently served
- sec_left, out, 8, ticks remaining in current state
- flashing, out, 1, high while in FLASH

Behaviour:
- Reset (async, rst=1):
  - red all ones; green, yellow, turn all zero; flashing=0.
  - state=ALLRED, cur_phase=0, nxt=0, sec_left=ALLRED_S.
  - prescaler=0, demand latch=0, blink synchroniser=0.
- Prescaler counts 0..TICK_DIV-1; tick is a 1-cycle pulse when count==TICK_DIV-1, then count wraps to 0.
- blink passes through a 2-FF synchroniser to give blink_s (2-cycle latency).
- Demand latch:
  - dem[i] is set by demand[i]=1 in any cycle.
  - dem[i] clears in the cycle phase i enters GREEN; clear wins over a simultaneous set for that phase.
- State timing:
  - Each state loads sec_left=duration on entry and decrements on tick.
  - A tick with sec_left==1 ends the state.
  - A state therefore lasts exactly duration ticks, measured from the first tick after entry.
- States and transitions:
  - GREEN: green[cur]=1; all other phases red. At end:
    - If blink_s=1, go to YELLOW.
    - Else if any dem[j]=1 for j!=cur, set nxt = first such j searching cyclically from cur+1, then go to TURN if TURN_S>0, else YELLOW.
    - Else reload GREEN_S and stay (rest in green; no yellow).
  - TURN: green[cur]=1 and turn[cur]=1. At end go to YELLOW.
  - YELLOW: yellow[cur]=1, green[cur]=0. At end go to ALLRED.
  - ALLRED: red all ones. At end:
    - If blink_s=1, go to FLASH.
    - Else set cur=nxt and go to GREEN.
  - FLASH:
    - red, green and turn all zero.
    - yellow = all ones when the flash bit is 1; flash bit toggles each tick and is 1 on entry.
    - flashing=1; sec_left holds 0.
    - When blink_s=0 at a tick: set cur=0, nxt=0 and go to ALLRED.
- Blink mid-cycle: a phase in GREEN or TURN is not cut short. It completes its timed state, then YELLOW and ALLRED, then FLASH. Clearance is never skipped.
- Outputs and timing:
  - All outputs are registered.
  - Lamp outputs change in the same cycle as the state register.
  - Exactly one of green/yellow/red is high per phase outside FLASH.
- Simultaneous demands: lowest cyclic distance from cur+1 wins.

Test Plan:
- Reset, TICK_DIV=10, no demand:
  - ALLRED for 2 ticks (20 cycles), then phase 0 GREEN.
  - Phase 0 rests in green indefinitely; red[3:1]=3'b111; sec_left reloads 30 every 30 ticks.
- Pulse demand[2] during phase 0 GREEN:
  - After GREEN ends: TURN(5), YELLOW(3), ALLRED(2), then cur_phase=2 GREEN.
  - dem[2] cleared on entry.
- demand=4'b1010 asserted together while cur=0:
  - Phase 1 is served first, then phase 3, then rest in phase 3 green.
  - Phase 2 is never served.
- TURN_S=0 build with demand[1]:
  - GREEN goes directly to YELLOW; turn stays 0 throughout.
- blink=1 at tick 10 of phase 0 GREEN:
  - GREEN runs to 30 ticks, then YELLOW 3, ALLRED 2, then FLASH.
  - yellow toggles 4'b1111/4'b0000 each tick; red=0; flashing=1.
  - blink=0 gives ALLRED 2 ticks, then phase 0 GREEN.
- Assert rst mid-YELLOW of phase 2:
  - Outputs go immediately (async) to all-red, cur_phase=0.
  - After release, sequence restarts as in the first scenario.
